// File: rtl/iq_pkg.sv
// ---------------------------------------------------------------------------
// iq_pkg
// Shared types for the collapsing issue queue.
//   IQ_PRF_W      : physical register number width used by the entry/wake types
//   IQ_PAYLOAD_W  : opaque uop payload width used by the entry type
//   iq_entry_t    : one queue slot (valid, rdy1, rdy2, prs1, prs2, pdst, dstwe, payload)
//   iq_wake_t     : one wakeup broadcast (valid, prf)
// The top-level PRF_W / PAYLOAD_W parameters must equal these constants,
// because the packed entry type is sized from them.
// ---------------------------------------------------------------------------
package iq_pkg;

    localparam int IQ_PRF_W     = 6;
    localparam int IQ_PAYLOAD_W = 64;

    typedef struct packed {
        logic                    valid;
        logic                    rdy1;
        logic                    rdy2;
        logic [IQ_PRF_W-1:0]     prs1;
        logic [IQ_PRF_W-1:0]     prs2;
        logic [IQ_PRF_W-1:0]     pdst;
        logic                    dstwe;
        logic [IQ_PAYLOAD_W-1:0] payload;
    } iq_entry_t;

    typedef struct packed {
        logic                valid;
        logic [IQ_PRF_W-1:0] prf;
    } iq_wake_t;

endpackage

// File: rtl/iq_select_oldest.sv
// ---------------------------------------------------------------------------
// iq_select_oldest
// Age-ordered multi-grant picker. Bit 0 of cand is the oldest slot.
// Walking the channels in ascending order, each channel whose allow bit is
// set takes the oldest candidate not yet granted; disallowed channels are
// skipped and do not consume a candidate.
// Ports:
//   cand      [DEPTH]         candidate vector (valid & both sources ready)
//   allow     [ISS_W]         channel may accept a uop this cycle
//   grant     [ISS_W][DEPTH]  one-hot slot grant per channel (0 if none)
//   gnt_valid [ISS_W]         channel received a grant
// ---------------------------------------------------------------------------
module iq_select_oldest #(
    parameter int DEPTH = 8,
    parameter int ISS_W = 2
) (
    input  logic [DEPTH-1:0]            cand,
    input  logic [ISS_W-1:0]            allow,
    output logic [ISS_W-1:0][DEPTH-1:0] grant,
    output logic [ISS_W-1:0]            gnt_valid
);

    always_comb begin
        logic [DEPTH-1:0] remaining;
        logic             found;
        remaining = cand;
        found     = 1'b0;
        grant     = '0;
        gnt_valid = '0;
        for (int k = 0; k < ISS_W; k++) begin
            found = 1'b0;
            if (allow[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!found && remaining[i]) begin
                        grant[k][i]  = 1'b1;
                        remaining[i] = 1'b0;
                        found        = 1'b1;
                    end
                end
            end
            gnt_valid[k] = found;
        end
    end

endmodule

// File: rtl/issue_queue_collapse.sv
// ---------------------------------------------------------------------------
// issue_queue_collapse
// Age-ordered collapsing issue queue. Valid entries always occupy slots
// 0..count-1 with slot 0 the oldest. Each cycle the oldest ready entries are
// offered to the issue channels, issued entries are removed at the edge and
// the survivors slide down, and a new dispatch group is appended behind them.
//
// Optional build macro: ISSUE_QUEUE_SPEC_WAKE_EN
//   defined   : every issuing channel with dstwe also wakes its pdst, so a
//               dependent uop can issue the cycle after its producer.
//   undefined : only wake_valid / wake_prf wake entries.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               discard every entry (beats same-cycle enq/issue)
//   enq_*               ENQ_W dispatch lanes (valid, payload, prs1/2, rdy1/2,
//                       pdst, dstwe); enq_ready accepts a whole group
//   wake_valid/wake_prf WAKE_W wakeup broadcast ports
//   iss_allow           per-channel back-pressure
//   iss_valid/payload/pdst/dstwe  ISS_W issue channels
//   count, empty        registered occupancy
// ---------------------------------------------------------------------------
module issue_queue_collapse
    import iq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ENQ_W     = 2,
    parameter int ISS_W     = 2,
    parameter int WAKE_W    = 4,
    parameter int PRF_W     = IQ_PRF_W,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [ENQ_W-1:0]           enq_valid,
    input  logic [ENQ_W*PAYLOAD_W-1:0] enq_payload,
    input  logic [ENQ_W*PRF_W-1:0]     enq_prs1,
    input  logic [ENQ_W*PRF_W-1:0]     enq_prs2,
    input  logic [ENQ_W-1:0]           enq_rdy1,
    input  logic [ENQ_W-1:0]           enq_rdy2,
    input  logic [ENQ_W*PRF_W-1:0]     enq_pdst,
    input  logic [ENQ_W-1:0]           enq_dstwe,
    output logic                       enq_ready,
    input  logic [WAKE_W-1:0]          wake_valid,
    input  logic [WAKE_W*PRF_W-1:0]    wake_prf,
    input  logic [ISS_W-1:0]           iss_allow,
    output logic [ISS_W-1:0]           iss_valid,
    output logic [ISS_W*PAYLOAD_W-1:0] iss_payload,
    output logic [ISS_W*PRF_W-1:0]     iss_pdst,
    output logic [ISS_W-1:0]           iss_dstwe,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef ISSUE_QUEUE_SPEC_WAKE_EN
    localparam int NW = WAKE_W + ISS_W;
`else
    localparam int NW = WAKE_W;
`endif

    iq_entry_t                  q_reg  [DEPTH];
    iq_entry_t                  q_next [DEPTH];
    logic [CW-1:0]              count_reg;
    logic [CW-1:0]              count_next;
    logic [DEPTH-1:0]           cand;
    logic [DEPTH-1:0]           iss_mask;
    logic [ISS_W-1:0][DEPTH-1:0] grant;
    iq_wake_t [NW-1:0]          wake_all;

    // True when any wake port (external, plus internal ones if enabled)
    // broadcasts this physical register this cycle.
    function automatic logic wake_hit(input logic [IQ_PRF_W-1:0] prf,
                                      input iq_wake_t [NW-1:0] w);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < NW; n++) begin
            if (w[n].valid && (w[n].prf == prf)) hit = 1'b1;
        end
        return hit;
    endfunction

    // ---------------- select ----------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cand
        assign cand[gi] = q_reg[gi].valid & q_reg[gi].rdy1 & q_reg[gi].rdy2;
    end

    iq_select_oldest #(
        .DEPTH (DEPTH),
        .ISS_W (ISS_W)
    ) u_select (
        .cand      (cand),
        .allow     (iss_allow),
        .grant     (grant),
        .gnt_valid (iss_valid)
    );

    always_comb begin
        iss_mask = '0;
        for (int k = 0; k < ISS_W; k++) iss_mask = iss_mask | grant[k];
    end

    // Issue channel muxes: grants are one-hot, so a simple scan suffices.
    for (genvar gi = 0; gi < ISS_W; gi++) begin : g_iss
        iq_entry_t sel;
        always_comb begin
            sel = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[gi][i]) sel = q_reg[i];
            end
        end
        assign iss_payload[gi*PAYLOAD_W +: PAYLOAD_W] = sel.payload;
        assign iss_pdst[gi*PRF_W +: PRF_W]            = sel.pdst;
        assign iss_dstwe[gi]                          = sel.dstwe & iss_valid[gi];
    end

    // ---------------- wake ports ----------------
    for (genvar gi = 0; gi < WAKE_W; gi++) begin : g_wake
        assign wake_all[gi].valid = wake_valid[gi];
        assign wake_all[gi].prf   = wake_prf[gi*PRF_W +: PRF_W];
    end
`ifdef ISSUE_QUEUE_SPEC_WAKE_EN
    // Issuing producers wake their consumers at the same edge as an
    // external broadcast would.
    for (genvar gi = 0; gi < ISS_W; gi++) begin : g_spec_wake
        assign wake_all[WAKE_W+gi].valid = iss_dstwe[gi];
        assign wake_all[WAKE_W+gi].prf   = iss_pdst[gi*PRF_W +: PRF_W];
    end
`endif

    // ---------------- occupancy ----------------
    // Credit only the registered count; same-cycle issues do not free room.
    assign enq_ready = (DEPTH - int'(count_reg)) >= ENQ_W;
    assign count     = count_reg;
    assign empty     = (count_reg == '0);

    // ---------------- collapse + enqueue ----------------
    // Survivors are written in age order starting at slot 0, so each one
    // lands on its old index minus the number of older issued entries.
    // New lanes are appended after the last survivor, compacted in lane order.
    always_comb begin
        int        slot;
        iq_entry_t ent;
        slot = 0;
        ent  = '0;
        for (int i = 0; i < DEPTH; i++) q_next[i] = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (q_reg[i].valid && !iss_mask[i]) begin
                ent      = q_reg[i];
                ent.rdy1 = ent.rdy1 | wake_hit(ent.prs1, wake_all);
                ent.rdy2 = ent.rdy2 | wake_hit(ent.prs2, wake_all);
                q_next[slot[AW-1:0]] = ent;
                slot = slot + 1;
            end
        end

        if (enq_ready) begin
            for (int l = 0; l < ENQ_W; l++) begin
                if (enq_valid[l]) begin
                    ent.valid   = 1'b1;
                    ent.prs1    = enq_prs1[l*PRF_W +: PRF_W];
                    ent.prs2    = enq_prs2[l*PRF_W +: PRF_W];
                    ent.rdy1    = enq_rdy1[l] | wake_hit(ent.prs1, wake_all);
                    ent.rdy2    = enq_rdy2[l] | wake_hit(ent.prs2, wake_all);
                    ent.pdst    = enq_pdst[l*PRF_W +: PRF_W];
                    ent.dstwe   = enq_dstwe[l];
                    ent.payload = enq_payload[l*PAYLOAD_W +: PAYLOAD_W];
                    if (slot < DEPTH) q_next[slot[AW-1:0]] = ent;
                    slot = slot + 1;
                end
            end
        end

        count_next = slot[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) q_reg[i] <= '0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q_reg[i] <= q_next[i];
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_issue_queue_collapse.sv
// ---------------------------------------------------------------------------
// tb_issue_queue_collapse
// Cycle table of directed vectors, a random all-ready traffic phase checked
// against an age-ordered scoreboard queue, and a producer/consumer sequence
// whose expectation depends on ISSUE_QUEUE_SPEC_WAKE_EN.
// ---------------------------------------------------------------------------
module tb_issue_queue_collapse;

    localparam int DEPTH = 8, ENQ_W = 2, ISS_W = 2, WAKE_W = 4;
    localparam int PRF_W = 6, PAYLOAD_W = 64;

    logic                       clk = 1'b0;
    logic                       rst, flush;
    logic [ENQ_W-1:0]           enq_valid;
    logic [ENQ_W*PAYLOAD_W-1:0] enq_payload;
    logic [ENQ_W*PRF_W-1:0]     enq_prs1, enq_prs2, enq_pdst;
    logic [ENQ_W-1:0]           enq_rdy1, enq_rdy2, enq_dstwe;
    logic                       enq_ready;
    logic [WAKE_W-1:0]          wake_valid;
    logic [WAKE_W*PRF_W-1:0]    wake_prf;
    logic [ISS_W-1:0]           iss_allow, iss_valid, iss_dstwe;
    logic [ISS_W*PAYLOAD_W-1:0] iss_payload;
    logic [ISS_W*PRF_W-1:0]     iss_pdst;
    logic [3:0]                 count;
    logic                       empty;

    always #5 clk = ~clk;

    issue_queue_collapse #(
        .DEPTH(DEPTH), .ENQ_W(ENQ_W), .ISS_W(ISS_W), .WAKE_W(WAKE_W),
        .PRF_W(PRF_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_payload(enq_payload),
        .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
        .enq_rdy1(enq_rdy1), .enq_rdy2(enq_rdy2),
        .enq_pdst(enq_pdst), .enq_dstwe(enq_dstwe), .enq_ready(enq_ready),
        .wake_valid(wake_valid), .wake_prf(wake_prf),
        .iss_allow(iss_allow), .iss_valid(iss_valid),
        .iss_payload(iss_payload), .iss_pdst(iss_pdst), .iss_dstwe(iss_dstwe),
        .count(count), .empty(empty)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       fl;
        logic [1:0] ev, r;
        logic [7:0] t0, t1;
        logic [5:0] p0, p1;
        logic       wk;
        logic [5:0] wp;
        logic [1:0] al, eiv;
        logic [7:0] et0, et1;
        logic [3:0] ec;
        logic       er;
    } vec_t;

    function automatic vec_t mk(int fl, int ev, int r, int t0, int t1, int p0, int p1,
                                int wk, int wp, int al, int eiv, int et0, int et1,
                                int ec, int er);
        vec_t v;
        v.fl = 1'(fl);   v.ev = 2'(ev);   v.r = 2'(r);
        v.t0 = 8'(t0);   v.t1 = 8'(t1);
        v.p0 = 6'(p0);   v.p1 = 6'(p1);
        v.wk = 1'(wk);   v.wp = 6'(wp);   v.al = 2'(al);
        v.eiv = 2'(eiv); v.et0 = 8'(et0); v.et1 = 8'(et1);
        v.ec = 4'(ec);   v.er = 1'(er);
        return v;
    endfunction

    task automatic idle_inputs();
        flush = 0; enq_valid = '0; enq_payload = '0;
        enq_prs1 = '0; enq_prs2 = '0; enq_rdy1 = '0; enq_rdy2 = '0;
        enq_pdst = '0; enq_dstwe = '0; wake_valid = '0; wake_prf = '0;
        iss_allow = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t       tbl[$];
    logic [63:0] sbq[$];

    initial begin
        logic [63:0] tag_ctr;
        rst = 1'b1;
        idle_inputs();
        repeat (3) next_cycle();
        rst = 1'b0;

        // ---------------- directed cycle table ----------------
        //            fl ev r  t0 t1 p0 p1 wk wp al eiv et0 et1 ec er
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 0,  0,  0, 0,1)); // reset state
        tbl.push_back(mk(0,3,3, 1, 2, 0, 0,0, 0,3, 0,  0,  0, 0,1)); // two ready uops
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 3,  1,  2, 2,1));
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 0,  0,  0, 0,1));
        tbl.push_back(mk(0,1,0, 3, 0, 5, 0,0, 0,3, 0,  0,  0, 0,1)); // waits on p5
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,1, 6,3, 0,  0,  0, 1,1)); // wrong prf
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,1, 5,3, 0,  0,  0, 1,1)); // wake p5
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 1,  3,  0, 1,1));
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 0,  0,  0, 0,1));
        tbl.push_back(mk(0,3,0,10,11,10,10,0, 0,0, 0,  0,  0, 0,1)); // fill
        tbl.push_back(mk(0,3,0,12,13,10,10,0, 0,0, 0,  0,  0, 2,1));
        tbl.push_back(mk(0,3,0,14,15,10,10,0, 0,0, 0,  0,  0, 4,1));
        tbl.push_back(mk(0,1,0,16, 0,10, 0,0, 0,0, 0,  0,  0, 6,1));
        tbl.push_back(mk(0,3,0,17,18,10,10,0, 0,0, 0,  0,  0, 7,0)); // ignored
        tbl.push_back(mk(0,3,0,19,20,10,10,1,10,0, 0,  0,  0, 7,0)); // ignored, wake all
        tbl.push_back(mk(0,3,3,40,41, 0, 0,0, 0,1, 1, 10,  0, 7,0)); // full, issue 1
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,0, 0,  0,  0, 6,1));
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 3, 11, 12, 6,1));
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 3, 13, 14, 4,1));
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 3, 15, 16, 2,1));
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 0,  0,  0, 0,1));
        tbl.push_back(mk(0,3,1,21,22, 0,20,0, 0,0, 0,  0,  0, 0,1)); // R, N
        tbl.push_back(mk(0,1,1,23, 0, 0, 0,0, 0,0, 0,  0,  0, 2,1)); // R
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,2, 2,  0, 21, 3,1)); // ch0 skipped
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,1, 1, 23,  0, 2,1));
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,1,20,0, 0,  0,  0, 1,1));
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 1, 22,  0, 1,1));
        tbl.push_back(mk(0,1,0,24, 0,30, 0,1,30,0, 0,  0,  0, 0,1)); // enq bypass wake
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 1, 24,  0, 1,1));
        tbl.push_back(mk(0,3,3,25,26, 0, 0,0, 0,0, 0,  0,  0, 0,1));
        tbl.push_back(mk(0,3,3,27,28, 0, 0,0, 0,1, 1, 25,  0, 2,1)); // enq + issue
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 3, 26, 27, 3,1));
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 1, 28,  0, 1,1));
        tbl.push_back(mk(0,3,3,29,30, 0, 0,0, 0,0, 0,  0,  0, 0,1));
        tbl.push_back(mk(1,3,3,31,32, 0, 0,0, 0,3, 3, 29, 30, 2,1)); // flush wins
        tbl.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0,3, 0,  0,  0, 0,1));

        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            idle_inputs();
            flush                 = v.fl;
            enq_valid             = v.ev;
            enq_payload[63:0]     = {56'd0, v.t0};
            enq_payload[127:64]   = {56'd0, v.t1};
            enq_prs1              = {v.p1, v.p0};
            enq_rdy1              = v.r;
            enq_rdy2              = 2'b11;
            wake_valid            = {3'b000, v.wk};
            wake_prf[5:0]         = v.wp;
            iss_allow             = v.al;
            #4;
            $display("row %0d: iss_valid=%b count=%0d enq_ready=%b", i, iss_valid, count, enq_ready);
            chk($sformatf("row%0d_iss_valid", i), 64'(iss_valid), 64'(v.eiv));
            if (v.eiv[0]) chk($sformatf("row%0d_ch0_payload", i), iss_payload[63:0], {56'd0, v.et0});
            if (v.eiv[1]) chk($sformatf("row%0d_ch1_payload", i), iss_payload[127:64], {56'd0, v.et1});
            chk($sformatf("row%0d_count", i), 64'(count), 64'(v.ec));
            chk($sformatf("row%0d_enq_ready", i), 64'(enq_ready), 64'(v.er));
            chk($sformatf("row%0d_empty", i), 64'(empty), 64'(v.ec == 4'd0));
            chk($sformatf("row%0d_iss_dstwe", i), 64'(iss_dstwe), 64'd0);
            next_cycle();
        end

        // ---------------- random all-ready traffic vs scoreboard ----------------
        tag_ctr = 64'h1000;
        for (int cyc = 0; cyc < 330; cyc++) begin
            int  sz, nallow;
            logic accept, exp_v;
            idle_inputs();
            sz = sbq.size();
            if (cyc < 300) begin
                iss_allow = 2'($urandom_range(0, 3));
                enq_valid = 2'($urandom_range(0, 3));
            end else begin
                iss_allow = 2'b11;
            end
            enq_rdy1 = 2'b11;
            enq_rdy2 = 2'b11;
            for (int l = 0; l < ENQ_W; l++) begin
                if (enq_valid[l]) begin
                    enq_payload[l*64 +: 64] = tag_ctr;
                    tag_ctr = tag_ctr + 1;
                end
            end
            accept = (DEPTH - sz) >= ENQ_W;
            #4;
            $display("rand %0d: allow=%b iss_valid=%b count=%0d model=%0d", cyc, iss_allow, iss_valid, count, sz);
            chk("rand_count", 64'(count), 64'(sz));
            chk("rand_enq_ready", 64'(enq_ready), 64'(accept));
            nallow = 0;
            for (int k = 0; k < ISS_W; k++) begin
                exp_v = iss_allow[k] && (nallow < sz);
                if (iss_allow[k]) nallow++;
                chk($sformatf("rand_iss_valid%0d", k), 64'(iss_valid[k]), 64'(exp_v));
                if (exp_v) chk($sformatf("rand_payload%0d", k), iss_payload[k*64 +: 64], sbq.pop_front());
            end
            if (accept) begin
                for (int l = 0; l < ENQ_W; l++)
                    if (enq_valid[l]) sbq.push_back(enq_payload[l*64 +: 64]);
            end
            next_cycle();
            if (cyc >= 300 && sbq.size() == 0) break;
        end
        chk("rand_drained", 64'(sbq.size()), 64'd0);

        // ---------------- producer -> consumer on p9 ----------------
        idle_inputs();
        enq_valid          = 2'b11;
        enq_payload[63:0]  = 64'hA0;
        enq_payload[127:64]= 64'hA1;
        enq_rdy1           = 2'b11;
        enq_rdy2           = 2'b01;           // consumer waits on prs2
        enq_prs2[11:6]     = 6'd9;
        enq_pdst[5:0]      = 6'd9;
        enq_dstwe          = 2'b01;
        iss_allow          = 2'b11;
        #4;
        chk("pc_enq_cycle_idle", 64'(iss_valid), 64'd0);
        next_cycle();
        idle_inputs();
        iss_allow = 2'b11;
        #4;
        $display("pc producer: iss_valid=%b pdst=%0d dstwe=%b", iss_valid, iss_pdst[5:0], iss_dstwe);
        chk("pc_prod_valid", 64'(iss_valid), 64'd1);
        chk("pc_prod_payload", iss_payload[63:0], 64'hA0);
        chk("pc_prod_pdst", 64'(iss_pdst[5:0]), 64'd9);
        chk("pc_prod_dstwe", 64'(iss_dstwe), 64'd1);
        next_cycle();
`ifdef ISSUE_QUEUE_SPEC_WAKE_EN
        #4;
        $display("pc consumer (internal wake): iss_valid=%b", iss_valid);
        chk("pc_cons_b2b_valid", 64'(iss_valid), 64'd1);
        chk("pc_cons_b2b_payload", iss_payload[63:0], 64'hA1);
        chk("pc_cons_b2b_dstwe", 64'(iss_dstwe), 64'd0);
        next_cycle();
        #4;
        chk("pc_after_valid", 64'(iss_valid), 64'd0);
        chk("pc_after_count", 64'(count), 64'd0);
`else
        wake_valid    = 4'b0100;              // external wake on port 2
        wake_prf[17:12] = 6'd9;
        #4;
        $display("pc consumer blocked: iss_valid=%b", iss_valid);
        chk("pc_cons_blocked", 64'(iss_valid), 64'd0);
        chk("pc_cons_count", 64'(count), 64'd1);
        next_cycle();
        idle_inputs();
        iss_allow = 2'b11;
        #4;
        $display("pc consumer woken: iss_valid=%b", iss_valid);
        chk("pc_cons_woken_valid", 64'(iss_valid), 64'd1);
        chk("pc_cons_woken_payload", iss_payload[63:0], 64'hA1);
`endif
        next_cycle();
        idle_inputs();
        #4;
        chk("pc_final_empty", 64'(empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
